// File: rtl/sequenciador_multiciclo.sv
// Multi-cycle sequencer: steps each instruction through fetch/decode/execute/
// memory/writeback and turns UniControle requests into single-cycle strobes.
module sequenciador_multiciclo #(
  parameter int LAT_MEM  = 1,
  parameter int CICLOS_W = 32
) (
  input  logic                clock,
  input  logic                reseta,
  input  logic                passo_a_passo,
  input  logic                botao_passo,
  input  logic                botao_in,
  input  logic                escreveR_uc,
  input  logic                escreveM_uc,
  input  logic                leM_uc,
  input  logic                halt_uc,
  input  logic                escreverIn_uc,
  input  logic                escreverOut_uc,
  output logic                carrega_ir,
  output logic                pc_avanca,
  output logic                escreveR,
  output logic                escreveM,
  output logic                escreverOut,
  output logic                aguardando_in,
  output logic                parado,
  output logic [2:0]          estado,
  output logic [CICLOS_W-1:0] ciclos,
  output logic [CICLOS_W-1:0] instrucoes
);

  typedef enum logic [2:0] {
    BUSCA      = 3'd0,
    DECODIFICA = 3'd1,
    EXECUTA    = 3'd2,
    MEMORIA    = 3'd3,
    ESCRITA    = 3'd4,
    ESPERA_IN  = 3'd5,
    PARADO     = 3'd6,
    PASSO      = 3'd7
  } estado_t;

  localparam int MW = (LAT_MEM > 1) ? $clog2(LAT_MEM) : 1;

  estado_t        st, st_nx;
  logic           esc_r_q, esc_m_q, le_m_q, esc_out_q;
  logic           in_q, passo_q;
  logic           espera_ok;
  logic [MW-1:0]  mem_cnt;
  logic           borda_in, borda_passo, mem_fim;
  logic           carrega_c, pc_c, esc_r_c, esc_m_c, esc_out_c;

  assign borda_in    = botao_in & ~in_q;
  assign borda_passo = botao_passo & ~passo_q;
  assign mem_fim     = (mem_cnt == MW'(LAT_MEM - 1));

  always_ff @(posedge clock) begin
    if (!reseta) begin
      st         <= BUSCA;
      esc_r_q    <= 1'b0;
      esc_m_q    <= 1'b0;
      le_m_q     <= 1'b0;
      esc_out_q  <= 1'b0;
      in_q       <= 1'b1;
      passo_q    <= 1'b1;
      espera_ok  <= 1'b0;
      mem_cnt    <= '0;
      ciclos     <= '0;
      instrucoes <= '0;
    end else begin
      st        <= st_nx;
      in_q      <= botao_in;
      passo_q   <= botao_passo;
      // low during the entry cycle of ESPERA_IN so stale edges are ignored
      espera_ok <= (st == ESPERA_IN);
      if (st == DECODIFICA) begin
        esc_r_q   <= escreveR_uc;
        esc_m_q   <= escreveM_uc;
        le_m_q    <= leM_uc;
        esc_out_q <= escreverOut_uc;
      end
      if (st == MEMORIA) mem_cnt <= mem_cnt + 1'b1;
      else               mem_cnt <= '0;
      if (st != PARADO && !(&ciclos)) ciclos <= ciclos + 1'b1;
      if (st == ESCRITA) instrucoes <= instrucoes + 1'b1;
    end
  end

  always_comb begin
    st_nx     = st;
    carrega_c = 1'b0;
    pc_c      = 1'b0;
    esc_r_c   = 1'b0;
    esc_m_c   = 1'b0;
    esc_out_c = 1'b0;
    unique case (st)
      BUSCA: begin
        carrega_c = 1'b1;
        st_nx     = DECODIFICA;
      end
      DECODIFICA: begin
        if (halt_uc)            st_nx = PARADO;
        else if (escreverIn_uc) st_nx = ESPERA_IN;
        else                    st_nx = EXECUTA;
      end
      EXECUTA: begin
        st_nx = (esc_m_q | le_m_q) ? MEMORIA : ESCRITA;
      end
      MEMORIA: begin
        esc_m_c = esc_m_q & (mem_cnt == '0);
        if (mem_fim) st_nx = ESCRITA;
      end
      ESCRITA: begin
        pc_c      = 1'b1;
        esc_r_c   = esc_r_q;
        esc_out_c = esc_out_q;
        st_nx     = passo_a_passo ? PASSO : BUSCA;
      end
      ESPERA_IN: begin
        if (espera_ok && borda_in) st_nx = ESCRITA;
      end
      PASSO: begin
        if (borda_passo || !passo_a_passo) st_nx = BUSCA;
      end
      PARADO: begin
        st_nx = PARADO;
      end
    endcase
  end

  // no strobe escapes while reset is held
  assign carrega_ir    = carrega_c & reseta;
  assign pc_avanca     = pc_c & reseta;
  assign escreveR      = esc_r_c & reseta;
  assign escreveM      = esc_m_c & reseta;
  assign escreverOut   = esc_out_c & reseta;
  assign aguardando_in = (st == ESPERA_IN);
  assign parado        = (st == PARADO);
  assign estado        = st;

endmodule

// File: tb/tb_sequenciador_multiciclo.sv
// Scoreboard bench for sequenciador_multiciclo: random instruction mix,
// expected strobe events queued by the driver, popped by a monitor.
module tb_sequenciador_multiciclo;

  localparam int LAT  = 3;
  localparam int CW   = 8;
  localparam int CMAX = 255;

  logic clock = 1'b0;
  logic reseta = 1'b0;
  logic passo_a_passo = 1'b0;
  logic botao_passo = 1'b0;
  logic botao_in = 1'b0;
  logic escreveR_uc = 1'b0;
  logic escreveM_uc = 1'b0;
  logic leM_uc = 1'b0;
  logic halt_uc = 1'b0;
  logic escreverIn_uc = 1'b0;
  logic escreverOut_uc = 1'b0;
  logic carrega_ir, pc_avanca, escreveR, escreveM, escreverOut;
  logic aguardando_in, parado;
  logic [2:0] estado;
  logic [CW-1:0] ciclos, instrucoes;

  sequenciador_multiciclo #(.LAT_MEM(LAT), .CICLOS_W(CW)) dut (
    .clock(clock), .reseta(reseta),
    .passo_a_passo(passo_a_passo), .botao_passo(botao_passo),
    .botao_in(botao_in), .escreveR_uc(escreveR_uc),
    .escreveM_uc(escreveM_uc), .leM_uc(leM_uc), .halt_uc(halt_uc),
    .escreverIn_uc(escreverIn_uc), .escreverOut_uc(escreverOut_uc),
    .carrega_ir(carrega_ir), .pc_avanca(pc_avanca),
    .escreveR(escreveR), .escreveM(escreveM),
    .escreverOut(escreverOut), .aguardando_in(aguardando_in),
    .parado(parado), .estado(estado), .ciclos(ciclos),
    .instrucoes(instrucoes)
  );

  always #5 clock = ~clock;

  // pulse code: 16 carrega_ir, 8 pc_avanca, 4 escreveR, 2 escreveM, 1 escreverOut
  typedef struct {
    int c;
    int p;
    int ins;
    int cic;
  } ev_t;

  ev_t q[$];
  int  exp_st[int];
  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  int  nxt = 0;
  int  n_ret = 0;

  always @(posedge clock) cyc <= reseta ? cyc + 1 : 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int c);
    return (c > CMAX) ? CMAX : c;
  endfunction

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic junk();
    escreveR_uc    = 1'($urandom);
    escreveM_uc    = 1'($urandom);
    leM_uc         = 1'($urandom);
    halt_uc        = 1'($urandom);
    escreverIn_uc  = 1'($urandom);
    escreverOut_uc = 1'($urandom);
  endtask

  always @(negedge clock) begin : mon
    ev_t e;
    int  p;
    p = int'({carrega_ir, pc_avanca, escreveR, escreveM, escreverOut});
    if (!reseta) begin
      chk("pulse_in_reset", p, 0);
    end else begin
      if (exp_st.exists(cyc)) begin
        chk("estado", int'(estado), exp_st[cyc]);
        chk("aguardando_in", int'(aguardando_in), int'(exp_st[cyc] == 5));
        chk("parado", int'(parado), int'(exp_st[cyc] == 6));
      end
      if (p != 0) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", p, 0);
        end else begin
          e = q.pop_front();
          chk("ev_cycle", cyc, e.c);
          chk("ev_pulses", p, e.p);
          chk("ev_instrucoes", int'(instrucoes), e.ins);
          chk("ev_ciclos", int'(ciclos), e.cic);
        end
      end
    end
  end

  task automatic do_reset(input int n);
    reseta = 1'b0;
    q.delete();
    exp_st.delete();
    repeat (n) @(posedge clock);
    #1;
    chk("rst_estado", int'(estado), 0);
    chk("rst_ciclos", int'(ciclos), 0);
    chk("rst_instrucoes", int'(instrucoes), 0);
    chk("rst_parado", int'(parado), 0);
    chk("rst_aguardando", int'(aguardando_in), 0);
    reseta = 1'b1;
    nxt = 0;
    n_ret = 0;
  endtask

  // kind: 0 ALU, 1 load, 2 store, 3 switch input; rsel<0 randomizes escreveR_uc
  task automatic run_instr(input int kind, input bit passo, input int rsel);
    int s, w, k, h, p;
    bit r, o, held;
    s = nxt;
    wait_cyc(s);
    passo_a_passo = passo;
    r = (rsel < 0) ? 1'($urandom) : (rsel != 0);
    o = 1'($urandom);
    held = 1'($urandom);
    q.push_back('{s, 16, n_ret % 256, sat(s)});
    exp_st[s] = 0;
    exp_st[s+1] = 1;
    wait_cyc(s + 1);
    escreveR_uc    = r;
    escreverOut_uc = o;
    escreveM_uc    = (kind == 2);
    leM_uc         = (kind == 1);
    escreverIn_uc  = (kind == 3);
    halt_uc        = 1'b0;
    if (kind == 3 && held) botao_in = 1'b1;
    wait_cyc(s + 2);
    junk();
    if (kind == 3) begin
      h = $urandom_range(1, 3);
      k = held ? s + 4 + h : s + 2 + h;
      for (int c = s + 2; c <= k; c++) exp_st[c] = 5;
      w = k + 1;
      if (held) begin
        wait_cyc(k - 1);
        botao_in = 1'b0;
      end
      wait_cyc(k);
      botao_in = 1'b1;
    end else begin
      exp_st[s+2] = 2;
      if (kind == 1 || kind == 2) begin
        for (int c = s + 3; c <= s + 2 + LAT; c++) exp_st[c] = 3;
        if (kind == 2) q.push_back('{s + 3, 2, n_ret % 256, sat(s + 3)});
        w = s + 3 + LAT;
      end else begin
        w = s + 3;
      end
    end
    q.push_back('{w, 8 + (r ? 4 : 0) + (o ? 1 : 0), n_ret % 256, sat(w)});
    exp_st[w] = 4;
    n_ret++;
    if (kind == 3) begin
      wait_cyc(w);
      botao_in = 1'b0;
    end
    if (passo) begin
      p = w + 1 + $urandom_range(0, 3);
      for (int c = w + 1; c <= p; c++) exp_st[c] = 7;
      wait_cyc(p);
      if ($urandom_range(0, 1) == 1) botao_passo = 1'b1;
      else                          passo_a_passo = 1'b0;
      wait_cyc(p + 1);
      botao_passo = 1'b0;
      nxt = p + 1;
    end else begin
      nxt = w + 1;
    end
  endtask

  task automatic reset_mid_exec();
    int s;
    s = nxt;
    wait_cyc(s);
    passo_a_passo = 1'b0;
    q.push_back('{s, 16, n_ret % 256, sat(s)});
    exp_st[s] = 0;
    exp_st[s+1] = 1;
    wait_cyc(s + 1);
    escreveM_uc = 1'b1;
    escreveR_uc = 1'b1;
    leM_uc = 1'b0;
    halt_uc = 1'b0;
    escreverIn_uc = 1'b0;
    wait_cyc(s + 2);
    do_reset(1);
  endtask

  task automatic run_halt();
    int s;
    s = nxt;
    wait_cyc(s);
    passo_a_passo = 1'b0;
    q.push_back('{s, 16, n_ret % 256, sat(s)});
    exp_st[s] = 0;
    exp_st[s+1] = 1;
    wait_cyc(s + 1);
    junk();
    halt_uc = 1'b1;
    escreverIn_uc = 1'b1;
    for (int c = s + 2; c <= s + 101; c++) exp_st[c] = 6;
    for (int i = 0; i < 100; i++) begin
      wait_cyc(s + 2 + i);
      junk();
      botao_in = 1'($urandom);
      botao_passo = 1'($urandom);
    end
    chk("halt_ciclos_frozen", int'(ciclos), sat(s + 2));
    chk("halt_instrucoes", int'(instrucoes), n_ret % 256);
    botao_in = 1'b0;
    botao_passo = 1'b0;
    do_reset(2);
  endtask

  initial begin
    do_reset(3);
    run_instr(0, 1'b0, 1);
    run_instr(2, 1'b0, -1);
    run_instr(1, 1'b0, -1);
    run_instr(3, 1'b0, 1);
    run_instr(0, 1'b1, -1);
    for (int i = 0; i < 300; i++)
      run_instr($urandom_range(0, 3), ($urandom_range(0, 5) == 0), -1);
    reset_mid_exec();
    for (int i = 0; i < 6; i++)
      run_instr($urandom_range(0, 3), ($urandom_range(0, 3) == 0), -1);
    run_halt();
    run_instr(2, 1'b1, 1);
    run_instr(0, 1'b0, -1);
    wait_cyc(nxt);
    chk("events_pending", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
